// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: scheduler state and fetcher state.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/fetcher.sv
// Per-core instruction fetcher: one program-memory read per FETCH, result held for the decoder.
// Define FETCHER_CACHE_EN to add a one-entry last-instruction cache that skips re-reading the same PC.
module fetcher
  import gpu_pkg::*;
#(
  parameter int prog_mem_addr_bits = 8,
  parameter int prog_mem_data_bits = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    core_state,
  input  logic [prog_mem_addr_bits-1:0] current_pc,
  output logic                          mem_read_valid,
  output logic [prog_mem_addr_bits-1:0] mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [prog_mem_data_bits-1:0] mem_read_data,
  output logic [2:0]                    fetcher_state,
  output logic [prog_mem_data_bits-1:0] instruction,
  output logic [15:0]                   fetch_count
);

  logic [2:0]                    r_state;
  logic                          r_memReadValid;
  logic [prog_mem_addr_bits-1:0] r_memReadAddress;
  logic [prog_mem_data_bits-1:0] r_instruction;
  logic [15:0]                   r_fetchCount;
  logic                          w_cacheHit;

`ifdef FETCHER_CACHE_EN
  // Tag is only ever invalidated by reset: program memory cannot change during a kernel.
  logic [prog_mem_addr_bits-1:0] r_tag;
  logic                          r_tagValid;

  assign w_cacheHit = r_tagValid && (r_tag == current_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag      <= '0;
      r_tagValid <= 1'b0;
    end else if (r_state == FETCHER_FETCHING && mem_read_ready) begin
      r_tag      <= r_memReadAddress;
      r_tagValid <= 1'b1;
    end
  end
`else
  assign w_cacheHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= FETCHER_IDLE;
      r_memReadValid   <= 1'b0;
      r_memReadAddress <= '0;
      r_instruction    <= '0;
      r_fetchCount     <= '0;
    end else begin
      case (r_state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (w_cacheHit) begin
              r_state <= FETCHER_FETCHED;
            end else begin
              r_memReadAddress <= current_pc;
              r_memReadValid   <= 1'b1;
              r_state          <= FETCHER_FETCHING;
            end
          end
        end
        // Address and valid stay frozen until the controller answers.
        FETCHER_FETCHING: begin
          if (mem_read_ready) begin
            r_instruction  <= mem_read_data;
            r_memReadValid <= 1'b0;
            r_fetchCount   <= r_fetchCount + 16'd1;
            r_state        <= FETCHER_FETCHED;
          end
        end
        FETCHER_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            r_state <= FETCHER_IDLE;
          end
        end
        default: begin
          r_state        <= FETCHER_IDLE;
          r_memReadValid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid   = r_memReadValid;
  assign mem_read_address = r_memReadAddress;
  assign fetcher_state    = r_state;
  assign instruction      = r_instruction;
  assign fetch_count      = r_fetchCount;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for fetcher; cache expectations follow FETCHER_CACHE_EN.
module tb_fetcher;

  logic        clk;
  logic        reset;
  logic [2:0]  coreState;
  logic [7:0]  currentPc;
  logic        memReadValid;
  logic [7:0]  memReadAddress;
  logic        memReadReady;
  logic [15:0] memReadData;
  logic [2:0]  fetcherState;
  logic [15:0] instruction;
  logic [15:0] fetchCount;

  int checks;
  int failures;

  localparam logic [2:0] CS_IDLE   = 3'b000;
  localparam logic [2:0] CS_FETCH  = 3'b001;
  localparam logic [2:0] CS_DECODE = 3'b010;
  localparam logic [2:0] FS_IDLE     = 3'b000;
  localparam logic [2:0] FS_FETCHING = 3'b001;
  localparam logic [2:0] FS_FETCHED  = 3'b010;

  fetcher #(
    .prog_mem_addr_bits(8),
    .prog_mem_data_bits(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (coreState),
    .current_pc       (currentPc),
    .mem_read_valid   (memReadValid),
    .mem_read_address (memReadAddress),
    .mem_read_ready   (memReadReady),
    .mem_read_data    (memReadData),
    .fetcher_state    (fetcherState),
    .instruction      (instruction),
    .fetch_count      (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge pass and settle 1ns past it.
  task automatic applyStimulus(input logic rst, input logic [2:0] cs, input logic [7:0] pc,
                               input logic rdy, input logic [15:0] data);
    reset        = rst;
    coreState    = cs;
    currentPc    = pc;
    memReadReady = rdy;
    memReadData  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] st, input logic v, input logic [7:0] addr,
                          input logic [15:0] ins, input logic [15:0] cnt);
    checkOutput({tag, ".state"}, 32'(fetcherState), 32'(st));
    checkOutput({tag, ".valid"}, 32'(memReadValid), 32'(v));
    checkOutput({tag, ".addr"},  32'(memReadAddress), 32'(addr));
    checkOutput({tag, ".instr"}, 32'(instruction), 32'(ins));
    checkOutput({tag, ".count"}, 32'(fetchCount), 32'(cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    $display("[TB] start");

    applyStimulus(1'b1, CS_IDLE, 8'h00, 1'b0, 16'h0000);
    applyStimulus(1'b1, CS_IDLE, 8'h00, 1'b0, 16'h0000);
    checkAll("reset", FS_IDLE, 1'b0, 8'h00, 16'h0000, 16'd0);

    // Basic fetch at pc 05 with ready on the third edge after the request; pc moves to 09 meanwhile.
    applyStimulus(1'b0, CS_FETCH, 8'h05, 1'b0, 16'h0000);
    checkAll("req", FS_FETCHING, 1'b1, 8'h05, 16'h0000, 16'd0);
    applyStimulus(1'b0, CS_FETCH, 8'h09, 1'b0, 16'h0000);
    checkAll("hold1", FS_FETCHING, 1'b1, 8'h05, 16'h0000, 16'd0);
    applyStimulus(1'b0, CS_FETCH, 8'h09, 1'b0, 16'h0000);
    checkAll("hold2", FS_FETCHING, 1'b1, 8'h05, 16'h0000, 16'd0);
    applyStimulus(1'b0, CS_FETCH, 8'h09, 1'b1, 16'hA1B2);
    checkAll("resp", FS_FETCHED, 1'b0, 8'h05, 16'hA1B2, 16'd1);

    // Stray ready in FETCHED is ignored.
    applyStimulus(1'b0, CS_FETCH, 8'h09, 1'b1, 16'hFFFF);
    checkAll("strayFetched", FS_FETCHED, 1'b0, 8'h05, 16'hA1B2, 16'd1);

    applyStimulus(1'b0, CS_DECODE, 8'h09, 1'b0, 16'h0000);
    checkAll("decode", FS_IDLE, 1'b0, 8'h05, 16'hA1B2, 16'd1);

    // Stray ready in IDLE is ignored.
    applyStimulus(1'b0, CS_IDLE, 8'h09, 1'b1, 16'hFFFF);
    checkAll("strayIdle", FS_IDLE, 1'b0, 8'h05, 16'hA1B2, 16'd1);

    // Re-fetch pc 05: hit with the cache, full request without it.
    applyStimulus(1'b0, CS_FETCH, 8'h05, 1'b0, 16'h0000);
`ifdef FETCHER_CACHE_EN
    checkAll("hit", FS_FETCHED, 1'b0, 8'h05, 16'hA1B2, 16'd1);
`else
    checkAll("refetch", FS_FETCHING, 1'b1, 8'h05, 16'hA1B2, 16'd1);
    applyStimulus(1'b0, CS_FETCH, 8'h05, 1'b1, 16'hA1B2);
    checkAll("refetchResp", FS_FETCHED, 1'b0, 8'h05, 16'hA1B2, 16'd2);
`endif
    applyStimulus(1'b0, CS_DECODE, 8'h05, 1'b0, 16'h0000);
    checkOutput("decode2.state", 32'(fetcherState), 32'(FS_IDLE));

    // Fetch pc 06 always misses; ready one edge after the request (minimum latency).
    applyStimulus(1'b0, CS_FETCH, 8'h06, 1'b0, 16'h0000);
`ifdef FETCHER_CACHE_EN
    checkAll("pc06req", FS_FETCHING, 1'b1, 8'h06, 16'hA1B2, 16'd1);
    applyStimulus(1'b0, CS_FETCH, 8'h06, 1'b1, 16'h5C3D);
    checkAll("pc06resp", FS_FETCHED, 1'b0, 8'h06, 16'h5C3D, 16'd2);
`else
    checkAll("pc06req", FS_FETCHING, 1'b1, 8'h06, 16'hA1B2, 16'd2);
    applyStimulus(1'b0, CS_FETCH, 8'h06, 1'b1, 16'h5C3D);
    checkAll("pc06resp", FS_FETCHED, 1'b0, 8'h06, 16'h5C3D, 16'd3);
`endif
    applyStimulus(1'b0, CS_DECODE, 8'h06, 1'b0, 16'h0000);
    checkOutput("decode3.state", 32'(fetcherState), 32'(FS_IDLE));

    // Reset mid-fetch aborts the request; a later ready is ignored.
    applyStimulus(1'b0, CS_FETCH, 8'h33, 1'b0, 16'h0000);
    checkOutput("midReq.state", 32'(fetcherState), 32'(FS_FETCHING));
    applyStimulus(1'b1, CS_FETCH, 8'h33, 1'b0, 16'h0000);
    checkAll("midReset", FS_IDLE, 1'b0, 8'h00, 16'h0000, 16'd0);
    applyStimulus(1'b0, CS_IDLE, 8'h33, 1'b1, 16'hBEEF);
    checkAll("postResetReady", FS_IDLE, 1'b0, 8'h00, 16'h0000, 16'd0);

    // After reset the cache tag is invalid, so pc 06 must issue a request.
    applyStimulus(1'b0, CS_FETCH, 8'h06, 1'b0, 16'h0000);
    checkAll("postResetFetch", FS_FETCHING, 1'b1, 8'h06, 16'h0000, 16'd0);
    applyStimulus(1'b0, CS_FETCH, 8'h06, 1'b1, 16'h0F0F);
    checkAll("postResetResp", FS_FETCHED, 1'b0, 8'h06, 16'h0F0F, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Per-core instruction fetcher; the program-memory reader side of the program-counter path. When the core scheduler enters FETCH, it issues one read request for the current PC to the program-memory controller and holds the address until the controller responds. It then presents the returned instruction to the decoder and reports FETCHED so the scheduler can advance. It sits between the scheduler/PC logic and the program-memory controller read channel, one instance per core.

## Interface
- prog_mem_addr_bits, 8, program-memory address width (matches PC width)
- prog_mem_data_bits, 16, instruction width
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- core_state  in  3  scheduler state: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
- current_pc  in  prog_mem_addr_bits  PC of the instruction to fetch
- mem_read_valid  out  1  read request valid to program-memory controller
- mem_read_address  out  prog_mem_addr_bits  request address, stable while valid
- mem_read_ready  in  1  controller response strobe; data valid this cycle
- mem_read_data  in  prog_mem_data_bits  returned instruction
- fetcher_state  out  3  IDLE 000, FETCHING 001, FETCHED 010
- instruction  out  prog_mem_data_bits  last fetched instruction, held until next fetch completes
- fetch_count  out  16  number of completed memory fetches, wraps at 16'hFFFF -> 0

## Operation
- IDLE: on core_state == FETCH -> latch current_pc into mem_read_address, assert mem_read_valid, go FETCHING. Other core_state values are ignored.
- FETCHING:
  - mem_read_valid stays high and mem_read_address stays frozen, even if current_pc changes.
  - On mem_read_ready -> capture mem_read_data into instruction, deassert mem_read_valid, increment fetch_count, go FETCHED.
- FETCHED: on core_state == DECODE -> go IDLE. instruction is held.
- mem_read_ready outside FETCHING is ignored: no capture, no count.
- Handshake: exactly one request per fetch. Valid never drops before ready. Ready is accepted only while valid is high.
- Codes 011–111 of fetcher_state are unused. If reached, the next edge goes to IDLE.

## Timing
- Reset values: fetcher_state IDLE, mem_read_valid 0, mem_read_address 0, instruction 0, fetch_count 0; cache tag invalid.
- Reset during FETCHING aborts the request: valid is 0 after that edge, and a later ready is ignored.
- Request latency: core_state == FETCH sampled at edge t -> mem_read_valid high after t.
- Response: ready sampled high at edge t+k (k ≥ 1) -> instruction and FETCHED visible after t+k.
- Minimum FETCH-to-FETCHED is 2 edges on a miss, 1 edge on a cache hit.
- FETCHED -> IDLE one edge after DECODE is sampled.

## Configuration
- FETCHER_CACHE_EN defined: one-entry last-instruction cache (tag register + valid bit, set on every completed fetch).
  - In IDLE with core_state == FETCH and current_pc == tag with valid set -> go directly to FETCHED.
  - On a hit: no request, instruction unchanged, fetch_count unchanged.
  - A miss behaves as the base design.
  - Valid is cleared only by reset; program memory is read-only during a kernel.
- Not defined: every fetch issues a memory request; no tag storage.

## Structure
- Shared package gpu_pkg holds:
  - core_state_t enum with the 3-bit encodings above (shared with scheduler and PC logic);
  - fetcher_state_t enum.
- No sub-module. Cache compare and tag register stay inline under the macro.

## Test plan
- Basic fetch: reset, current_pc=8'h05, core_state=FETCH, ready after 3 cycles with data 16'hA1B2 -> valid high 3 cycles at address 05, instruction=A1B2, fetcher_state=FETCHED, fetch_count=1.
- Address hold: change current_pc 05->09 during FETCHING -> mem_read_address stays 05 until ready.
- Stray ready: pulse mem_read_ready in IDLE and in FETCHED with data FFFF -> instruction and fetch_count unchanged.
- Reset mid-fetch: reset while FETCHING, then ready -> valid 0, state IDLE, instruction 0, count 0.
- Return path: FETCHED, core_state=DECODE -> IDLE next edge; second FETCH at pc 06 issues a new request.
- Cache (FETCHER_CACHE_EN):
  - Fetch pc 05, then FETCH at pc 05 again -> FETCHED in 1 edge, no valid pulse, count stays 1.
  - Then fetch pc 06 -> request issued.
